// File: rtl/par2ser_if.sv
// Stream bundle between a word producer, the parallel-to-serial converter and
// the serial consumer.
interface par2ser_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2
);
  logic                   par_valid;
  logic [DATA_W-1:0]      par_data;
  logic                   par_ready;
  logic                   ser_ready;
  logic                   output_valid;
  logic                   out;
  logic                   out_last;
  logic [$clog2(DEPTH):0] fifo_level;

  modport master (
    output par_valid, par_data, ser_ready,
    input  par_ready, output_valid, out, out_last, fifo_level
  );

  modport slave (
    input  par_valid, par_data, ser_ready,
    output par_ready, output_valid, out, out_last, fifo_level
  );
endinterface

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter: words enter a small FIFO, then shift out one
// bit per accepted cycle with a word-end marker on the final bit.
module par2ser_stream #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      rstn,
  par2ser_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              ready_q;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              push, pop, nonempty, last_bit, shifting;

  assign push     = bus.par_valid & ready_q;
  assign nonempty = (level_q != '0);
  assign last_bit = (cnt_q == LastCnt);
  assign shifting = (state_q == StShift);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (nonempty) begin
          pop     = 1'b1;
          sreg_d  = mem_q[rptr_q];
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.ser_ready) begin
          if (last_bit) begin
            // Reload from the FIFO on the final bit so words stay contiguous.
            if (nonempty) begin
              pop    = 1'b1;
              sreg_d = mem_q[rptr_q];
            end else begin
              sreg_d  = '0;
              state_d = StIdle;
            end
            cnt_d = '0;
          end else begin
            sreg_d = MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      // Registered ready looks ahead at next-cycle occupancy; no pass-through when full.
      ready_q <= (level_d != FullLvl);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.par_data;
  end

  assign bus.par_ready    = ready_q;
  assign bus.output_valid = shifting;
  assign bus.out          = shifting & (MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0]);
  assign bus.out_last     = shifting & last_bit;
  assign bus.fifo_level   = level_q;
endmodule
